// File: rtl/ledcomm_bridge_ctrl_if.sv
// Byte handshake bundle between the bridge controller and the UART / ledcomm cores.
interface ledcomm_bridge_ctrl_if;
  // UART side
  logic       serial_valid;
  logic [7:0] serial_data;
  logic       serial_busy;
  logic       serial_rd;
  logic       serial_wr;
  logic [7:0] serial_tx_data;
  // ledcomm side
  logic       ledcomm_valid;
  logic [7:0] ledcomm_rx_data;
  logic       ledcomm_busy;
  logic       ledcomm_link;
  logic       ledcomm_rd;
  logic       ledcomm_wr;
  logic [7:0] ledcomm_tx_data;

  // Bridge controller view
  modport master (
    input  serial_valid, serial_data, serial_busy,
    input  ledcomm_valid, ledcomm_rx_data, ledcomm_busy, ledcomm_link,
    output serial_rd, serial_wr, serial_tx_data,
    output ledcomm_rd, ledcomm_wr, ledcomm_tx_data
  );

  // Core-side view (UART + ledcomm)
  modport slave (
    output serial_valid, serial_data, serial_busy,
    output ledcomm_valid, ledcomm_rx_data, ledcomm_busy, ledcomm_link,
    input  serial_rd, serial_wr, serial_tx_data,
    input  ledcomm_rd, ledcomm_wr, ledcomm_tx_data
  );
endinterface

// File: rtl/ledcomm_bridge_ctrl.sv
// Bridge between the byte UART and the ledcommflow link: buffered both ways,
// strobe pacing, link-down dropping and an in-band escape command parser that
// drives the ledcomm timebase / charging / darkness settings.
module ledcomm_bridge_ctrl #(
  parameter int unsigned FIFO_AW      = 2,
  parameter logic [7:0]  ESC          = 8'h1B,
  parameter logic [15:0] TIMEBASE_RST = 16'd600,
  parameter logic [15:0] CHARGING_RST = 16'd12
) (
  input  logic                 clk,
  input  logic                 reset,
  ledcomm_bridge_ctrl_if.master bus,
  output logic                 darkness,
  output logic [15:0]          timebase,
  output logic [15:0]          charging,
  output logic [7:0]           drop_count,
  output logic                 cfg_strobe
);

  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned SUM_W = 16;

  localparam logic [7:0] CMD_T  = 8'h54;
  localparam logic [7:0] CMD_C  = 8'h43;
  localparam logic [7:0] CMD_D  = 8'h44;
  localparam logic [7:0] CMD_DL = 8'h64;

  typedef enum logic [1:0] {I_IDLE, I_ACK, I_GAP} ing_state_t;
  typedef enum logic [1:0] {P_DATA, P_CMD, P_HI, P_LO} parse_state_t;
  typedef enum logic [1:0] {E_IDLE, E_WR, E_GAP1, E_GAP2} egr_state_t;
  typedef enum logic [1:0] {L_IDLE, L_ACK, L_GAP} lin_state_t;
  typedef enum logic [1:0] {U_IDLE, U_WR, U_GAP1, U_GAP2} uegr_state_t;

  // ---------------------------------------------------------------- TX FIFO (UART -> ledcomm)
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_push_ok, tx_pop_ok, tx_flush;
  logic [7:0]    tx_head;

  // ---------------------------------------------------------------- RX FIFO (ledcomm -> UART)
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic          rx_full, rx_empty, rx_push, rx_pop, rx_push_ok, rx_pop_ok;
  logic [7:0]    rx_head;

  // ---------------------------------------------------------------- link edge detect
  logic link_q;

  // ---------------------------------------------------------------- FSM state
  ing_state_t   i_state, i_next;
  parse_state_t p_state, p_next;
  egr_state_t   e_state, e_next;
  lin_state_t   l_state, l_next;
  uegr_state_t  u_state, u_next;

  logic       i_latch, can_take, byte_v;
  logic [7:0] in_byte;
  logic       e_load, u_load;

  logic        tgt_charging, tgt_next;
  logic [7:0]  hi_byte, hi_next;
  logic [15:0] tb_next, ch_next, cmd_val;
  logic        dk_next, strobe_next, is_data, drop_inc;
  logic [SUM_W-1:0] drop_sum;
  logic [7:0]  drop_next;

  // TX FIFO status and handshake qualification
  assign tx_empty   = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full    = (tx_wr_ptr[FIFO_AW] != tx_rd_ptr[FIFO_AW]) &&
                      (tx_wr_ptr[FIFO_AW-1:0] == tx_rd_ptr[FIFO_AW-1:0]);
  assign tx_head    = tx_mem[tx_rd_ptr[FIFO_AW-1:0]];
  assign tx_count   = tx_wr_ptr - tx_rd_ptr;
  assign tx_pop_ok  = tx_pop && !tx_empty;
  assign tx_push_ok = tx_push && !tx_flush && (!tx_full || tx_pop_ok);

  // RX FIFO status and handshake qualification
  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full    = (rx_wr_ptr[FIFO_AW] != rx_rd_ptr[FIFO_AW]) &&
                      (rx_wr_ptr[FIFO_AW-1:0] == rx_rd_ptr[FIFO_AW-1:0]);
  assign rx_head    = rx_mem[rx_rd_ptr[FIFO_AW-1:0]];
  assign rx_pop_ok  = rx_pop && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);

  // Falling link flushes whatever is still queued for the link
  assign tx_flush = link_q && !bus.ledcomm_link;

  // TX FIFO pointers; a flush discards everything up to the write pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else if (tx_flush) begin
      tx_rd_ptr <= tx_wr_ptr;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= in_byte;
  end

  // RX FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= bus.ledcomm_rx_data;
  end

  // Link level history for the edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) link_q <= 1'b0;
    else       link_q <= bus.ledcomm_link;
  end

  // UART ingress: only take a byte when the parser has somewhere to put it
  assign can_take = (p_state != P_DATA) || !tx_full || !bus.ledcomm_link;
  assign byte_v   = (i_state == I_ACK);

  // UART ingress next-state
  always_comb begin
    i_next  = i_state;
    i_latch = 1'b0;
    case (i_state)
      I_IDLE: if (bus.serial_valid && can_take) begin
        i_latch = 1'b1;
        i_next  = I_ACK;
      end
      I_ACK:   i_next = I_GAP;
      I_GAP:   i_next = I_IDLE;
      default: i_next = I_IDLE;
    endcase
  end

  // UART ingress state, byte latch and serial_rd pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_state       <= I_IDLE;
      in_byte       <= '0;
      bus.serial_rd <= 1'b0;
    end else begin
      i_state       <= i_next;
      if (i_latch) in_byte <= bus.serial_data;
      bus.serial_rd <= (i_next == I_ACK);
    end
  end

  // Escape parser next-state and config register updates
  always_comb begin
    p_next      = p_state;
    tgt_next    = tgt_charging;
    hi_next     = hi_byte;
    tb_next     = timebase;
    ch_next     = charging;
    dk_next     = darkness;
    strobe_next = 1'b0;
    is_data     = 1'b0;
    cmd_val     = {hi_byte, in_byte};
    if (byte_v) begin
      case (p_state)
        P_DATA: begin
          if (in_byte == ESC) p_next = P_CMD;
          else                is_data = 1'b1;
        end
        P_CMD: begin
          p_next = P_DATA;
          case (in_byte)
            ESC:    is_data = 1'b1;
            CMD_T:  begin tgt_next = 1'b0; p_next = P_HI; end
            CMD_C:  begin tgt_next = 1'b1; p_next = P_HI; end
            CMD_D:  begin dk_next = 1'b1; strobe_next = 1'b1; end
            CMD_DL: begin dk_next = 1'b0; strobe_next = 1'b1; end
            default: ;
          endcase
        end
        P_HI: begin
          hi_next = in_byte;
          p_next  = P_LO;
        end
        P_LO: begin
          p_next = P_DATA;
          if (tgt_charging) begin
            ch_next     = cmd_val;
            strobe_next = 1'b1;
          end else if (cmd_val >= 16'd2) begin
            tb_next     = cmd_val;
            strobe_next = 1'b1;
          end
        end
        default: p_next = P_DATA;
      endcase
    end
    tx_push  = is_data && bus.ledcomm_link;
    drop_inc = is_data && !bus.ledcomm_link;
  end

  // Dropped bytes: link-down data plus whatever a flush threw away, saturating
  assign drop_sum  = SUM_W'(drop_count) + (tx_flush ? SUM_W'(tx_count) : SUM_W'(0)) +
                     SUM_W'(drop_inc);
  assign drop_next = (drop_sum > SUM_W'(255)) ? 8'hFF : drop_sum[7:0];

  // Parser state and config registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state      <= P_DATA;
      tgt_charging <= 1'b0;
      hi_byte      <= '0;
      timebase     <= TIMEBASE_RST;
      charging     <= CHARGING_RST;
      darkness     <= 1'b0;
      cfg_strobe   <= 1'b0;
      drop_count   <= '0;
    end else begin
      p_state      <= p_next;
      tgt_charging <= tgt_next;
      hi_byte      <= hi_next;
      timebase     <= tb_next;
      charging     <= ch_next;
      darkness     <= dk_next;
      cfg_strobe   <= strobe_next;
      drop_count   <= drop_next;
    end
  end

  // Ledcomm egress next-state; two gap cycles cover the busy assertion lag
  always_comb begin
    e_next = e_state;
    e_load = 1'b0;
    case (e_state)
      E_IDLE: if (!tx_empty && bus.ledcomm_link && !bus.ledcomm_busy) begin
        e_load = 1'b1;
        e_next = E_WR;
      end
      E_WR:    e_next = E_GAP1;
      E_GAP1:  e_next = E_GAP2;
      E_GAP2:  e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end
  assign tx_pop = e_load;

  // Ledcomm egress state, data and write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_state             <= E_IDLE;
      bus.ledcomm_tx_data <= '0;
      bus.ledcomm_wr      <= 1'b0;
    end else begin
      e_state        <= e_next;
      if (e_load) bus.ledcomm_tx_data <= tx_head;
      bus.ledcomm_wr <= (e_next == E_WR);
    end
  end

  // Ledcomm ingress next-state; a full RX FIFO leaves the byte in the core
  always_comb begin
    l_next  = l_state;
    rx_push = 1'b0;
    case (l_state)
      L_IDLE: if (bus.ledcomm_valid && !rx_full) begin
        rx_push = 1'b1;
        l_next  = L_ACK;
      end
      L_ACK:   l_next = L_GAP;
      L_GAP:   l_next = L_IDLE;
      default: l_next = L_IDLE;
    endcase
  end

  // Ledcomm ingress state and read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_state        <= L_IDLE;
      bus.ledcomm_rd <= 1'b0;
    end else begin
      l_state        <= l_next;
      bus.ledcomm_rd <= (l_next == L_ACK);
    end
  end

  // UART egress next-state
  always_comb begin
    u_next = u_state;
    u_load = 1'b0;
    case (u_state)
      U_IDLE: if (!rx_empty && !bus.serial_busy) begin
        u_load = 1'b1;
        u_next = U_WR;
      end
      U_WR:    u_next = U_GAP1;
      U_GAP1:  u_next = U_GAP2;
      U_GAP2:  u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end
  assign rx_pop = u_load;

  // UART egress state, data and write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state            <= U_IDLE;
      bus.serial_tx_data <= '0;
      bus.serial_wr      <= 1'b0;
    end else begin
      u_state       <= u_next;
      if (u_load) bus.serial_tx_data <= rx_head;
      bus.serial_wr <= (u_next == U_WR);
    end
  end

endmodule

// File: tb/tb_ledcomm_bridge_ctrl.sv
// Directed bench for ledcomm_bridge_ctrl: forwarding, escape commands, link loss,
// backpressure, reverse path and asynchronous reset.
module tb_ledcomm_bridge_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        darkness, cfg_strobe;
  logic [15:0] timebase, charging;
  logic [7:0]  drop_count;

  int vectors     = 0;
  int miscompares = 0;

  ledcomm_bridge_ctrl_if bus();

  ledcomm_bridge_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .darkness   (darkness),
    .timebase   (timebase),
    .charging   (charging),
    .drop_count (drop_count),
    .cfg_strobe (cfg_strobe)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge
  int         n_srd, n_lrd, n_cfg;
  logic [7:0] lw_q[$];
  logic [7:0] sw_q[$];
  always @(negedge clk) begin
    if (bus.serial_rd === 1'b1)  n_srd++;
    if (bus.ledcomm_rd === 1'b1) n_lrd++;
    if (cfg_strobe === 1'b1)     n_cfg++;
    if (bus.ledcomm_wr === 1'b1) lw_q.push_back(bus.ledcomm_tx_data);
    if (bus.serial_wr === 1'b1)  sw_q.push_back(bus.serial_tx_data);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic clr_mon;
    @(posedge clk); #1;
    n_srd = 0; n_lrd = 0; n_cfg = 0;
    lw_q.delete(); sw_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    bus.serial_valid = 1'b0; bus.serial_data = '0; bus.serial_busy = 1'b0;
    bus.ledcomm_valid = 1'b0; bus.ledcomm_rx_data = '0;
    bus.ledcomm_busy = 1'b0; bus.ledcomm_link = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    clr_mon();
  endtask

  task automatic send_uart(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    bus.serial_valid = 1'b1; bus.serial_data = b;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.serial_rd === 1'b1) got = 1;
    end
    bus.serial_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL uart_accept byte %02h: serial_rd observed 0 within 40 cycles, required 1", b);
    end
  endtask

  task automatic send_lc(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    bus.ledcomm_valid = 1'b1; bus.ledcomm_rx_data = b;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.ledcomm_rd === 1'b1) got = 1;
    end
    bus.ledcomm_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ledcomm_accept byte %02h: ledcomm_rd observed 0 within 40 cycles, required 1", b);
    end
  endtask

  task automatic test_reset;
    apply_reset();
    vectors++;
    if (timebase !== 16'd600) begin miscompares++; $display("FAIL reset_timebase: got %0d want 600", timebase); end
    vectors++;
    if (charging !== 16'd12) begin miscompares++; $display("FAIL reset_charging: got %0d want 12", charging); end
    vectors++;
    if ({darkness, cfg_strobe, drop_count} !== 10'd0) begin
      miscompares++; $display("FAIL reset_cfg: dark=%b strobe=%b drop=%0d want all 0", darkness, cfg_strobe, drop_count);
    end
    vectors++;
    if ({bus.serial_rd, bus.serial_wr, bus.ledcomm_rd, bus.ledcomm_wr, bus.serial_tx_data, bus.ledcomm_tx_data} !== 20'd0) begin
      miscompares++; $display("FAIL reset_strobes: srd=%b swr=%b lrd=%b lwr=%b stx=%02h ltx=%02h want all 0",
        bus.serial_rd, bus.serial_wr, bus.ledcomm_rd, bus.ledcomm_wr, bus.serial_tx_data, bus.ledcomm_tx_data);
    end
  endtask

  task automatic test_forward;
    logic [7:0] exp [3];
    logic [7:0] got;
    exp = '{8'h41, 8'h42, 8'h43};
    apply_reset();
    bus.ledcomm_link = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 3; i++) send_uart(exp[i]);
    wait_cyc(20);
    vectors++;
    if (n_srd !== 3) begin miscompares++; $display("FAIL fwd_serial_rd: got %0d pulses want 3", n_srd); end
    vectors++;
    if (lw_q.size() !== 3) begin miscompares++; $display("FAIL fwd_wr_count: got %0d want 3", lw_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < lw_q.size()) ? lw_q[i] : 8'hxx;
      vectors++;
      if (got !== exp[i]) begin miscompares++; $display("FAIL fwd_data[%0d]: got %02h want %02h", i, got, exp[i]); end
    end
    vectors++;
    if (drop_count !== 8'd0) begin miscompares++; $display("FAIL fwd_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_link_down_cmd;
    apply_reset();
    send_uart(8'h55); send_uart(8'h56);
    wait_cyc(10);
    vectors++;
    if (lw_q.size() !== 0) begin miscompares++; $display("FAIL down_no_wr: got %0d writes want 0", lw_q.size()); end
    vectors++;
    if (drop_count !== 8'd2) begin miscompares++; $display("FAIL down_drop: got %0d want 2", drop_count); end
    send_uart(8'h1B); send_uart(8'h54); send_uart(8'h01); send_uart(8'h2C);
    wait_cyc(3);
    vectors++;
    if (timebase !== 16'd300) begin miscompares++; $display("FAIL tb_set: got %0d want 300", timebase); end
    vectors++;
    if (n_cfg !== 1) begin miscompares++; $display("FAIL tb_set_strobe: got %0d want 1", n_cfg); end
    send_uart(8'h1B); send_uart(8'h54); send_uart(8'h00); send_uart(8'h01);
    wait_cyc(3);
    vectors++;
    if (timebase !== 16'd300) begin miscompares++; $display("FAIL tb_reject: got %0d want 300", timebase); end
    vectors++;
    if (n_cfg !== 1) begin miscompares++; $display("FAIL tb_reject_strobe: got %0d want 1", n_cfg); end
    send_uart(8'h1B); send_uart(8'h54); send_uart(8'h00); send_uart(8'h02);
    wait_cyc(3);
    vectors++;
    if (timebase !== 16'd2) begin miscompares++; $display("FAIL tb_min: got %0d want 2", timebase); end
    send_uart(8'h1B); send_uart(8'h43); send_uart(8'h00); send_uart(8'h00);
    wait_cyc(3);
    vectors++;
    if (charging !== 16'd0) begin miscompares++; $display("FAIL ch_zero: got %0d want 0", charging); end
    vectors++;
    if (n_cfg !== 3) begin miscompares++; $display("FAIL cfg_count: got %0d want 3", n_cfg); end
    vectors++;
    if (drop_count !== 8'd2) begin miscompares++; $display("FAIL cmd_not_dropped: got %0d want 2", drop_count); end
  endtask

  task automatic test_escape;
    logic [7:0] got;
    apply_reset();
    bus.ledcomm_link = 1'b1;
    wait_cyc(2);
    send_uart(8'h1B); send_uart(8'h1B);
    wait_cyc(10);
    vectors++;
    if (lw_q.size() !== 1) begin miscompares++; $display("FAIL esc_lit_count: got %0d want 1", lw_q.size()); end
    got = (lw_q.size() > 0) ? lw_q[0] : 8'hxx;
    vectors++;
    if (got !== 8'h1B) begin miscompares++; $display("FAIL esc_lit_data: got %02h want 1b", got); end
    send_uart(8'h1B); send_uart(8'h44);
    wait_cyc(3);
    vectors++;
    if (darkness !== 1'b1) begin miscompares++; $display("FAIL dark_on: got %b want 1", darkness); end
    send_uart(8'h1B); send_uart(8'h64);
    wait_cyc(3);
    vectors++;
    if (darkness !== 1'b0) begin miscompares++; $display("FAIL dark_off: got %b want 0", darkness); end
    send_uart(8'h1B); send_uart(8'h7A); send_uart(8'h30);
    wait_cyc(12);
    vectors++;
    if (lw_q.size() !== 2) begin miscompares++; $display("FAIL esc_unknown_count: got %0d want 2", lw_q.size()); end
    got = (lw_q.size() > 1) ? lw_q[1] : 8'hxx;
    vectors++;
    if (got !== 8'h30) begin miscompares++; $display("FAIL esc_unknown_data: got %02h want 30", got); end
    vectors++;
    if (n_cfg !== 2) begin miscompares++; $display("FAIL esc_strobes: got %0d want 2", n_cfg); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [6];
    logic [7:0] got;
    bit acc = 0;
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    apply_reset();
    bus.ledcomm_link = 1'b1; bus.ledcomm_busy = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 4; i++) send_uart(exp[i]);
    @(negedge clk);
    bus.serial_valid = 1'b1; bus.serial_data = exp[4];
    wait_cyc(20);
    vectors++;
    if (n_srd !== 4) begin miscompares++; $display("FAIL bp_stall: got %0d serial_rd want 4", n_srd); end
    vectors++;
    if (lw_q.size() !== 0) begin miscompares++; $display("FAIL bp_busy_wr: got %0d writes want 0", lw_q.size()); end
    bus.ledcomm_busy = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (bus.serial_rd === 1'b1) acc = 1;
    end
    bus.serial_valid = 1'b0;
    vectors++;
    if (!acc) begin miscompares++; $display("FAIL bp_resume: serial_rd got 0 want 1 after release"); end
    send_uart(exp[5]);
    wait_cyc(40);
    vectors++;
    if (lw_q.size() !== 6) begin miscompares++; $display("FAIL bp_count: got %0d want 6", lw_q.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < lw_q.size()) ? lw_q[i] : 8'hxx;
      vectors++;
      if (got !== exp[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %02h want %02h", i, got, exp[i]); end
    end
  endtask

  task automatic test_link_loss;
    apply_reset();
    bus.ledcomm_link = 1'b1; bus.ledcomm_busy = 1'b1;
    wait_cyc(2);
    send_uart(8'h21); send_uart(8'h22); send_uart(8'h23);
    wait_cyc(3);
    vectors++;
    if (drop_count !== 8'd0) begin miscompares++; $display("FAIL loss_pre: got %0d want 0", drop_count); end
    bus.ledcomm_link = 1'b0;
    wait_cyc(5);
    vectors++;
    if (drop_count !== 8'd3) begin miscompares++; $display("FAIL loss_flush: got %0d want 3", drop_count); end
    bus.ledcomm_busy = 1'b0;
    wait_cyc(20);
    vectors++;
    if (lw_q.size() !== 0) begin miscompares++; $display("FAIL loss_no_wr: got %0d writes want 0", lw_q.size()); end
    for (int i = 0; i < 251; i++) send_uart(8'h30);
    wait_cyc(3);
    vectors++;
    if (drop_count !== 8'd254) begin miscompares++; $display("FAIL loss_preload: got %0d want 254", drop_count); end
    @(negedge clk);
    bus.ledcomm_busy = 1'b1; bus.ledcomm_link = 1'b1;
    wait_cyc(2);
    send_uart(8'h31); send_uart(8'h32); send_uart(8'h33);
    wait_cyc(2);
    bus.ledcomm_link = 1'b0;
    wait_cyc(5);
    vectors++;
    if (drop_count !== 8'd255) begin miscompares++; $display("FAIL loss_sat_flush: got %0d want 255", drop_count); end
    send_uart(8'h34);
    wait_cyc(3);
    vectors++;
    if (drop_count !== 8'd255) begin miscompares++; $display("FAIL loss_sat_inc: got %0d want 255", drop_count); end
  endtask

  task automatic test_uart_egress_reset;
    logic [7:0] got;
    apply_reset();
    bus.serial_busy = 1'b1;
    wait_cyc(1);
    send_lc(8'hA0); send_lc(8'hA1);
    wait_cyc(10);
    vectors++;
    if (n_lrd !== 2) begin miscompares++; $display("FAIL rx_rd_count: got %0d want 2", n_lrd); end
    vectors++;
    if (sw_q.size() !== 0) begin miscompares++; $display("FAIL rx_busy_wr: got %0d writes want 0", sw_q.size()); end
    bus.serial_busy = 1'b0;
    wait_cyc(15);
    vectors++;
    if (sw_q.size() !== 2) begin miscompares++; $display("FAIL rx_wr_count: got %0d want 2", sw_q.size()); end
    got = (sw_q.size() > 0) ? sw_q[0] : 8'hxx;
    vectors++;
    if (got !== 8'hA0) begin miscompares++; $display("FAIL rx_data[0]: got %02h want a0", got); end
    got = (sw_q.size() > 1) ? sw_q[1] : 8'hxx;
    vectors++;
    if (got !== 8'hA1) begin miscompares++; $display("FAIL rx_data[1]: got %02h want a1", got); end
    send_uart(8'h1B); send_uart(8'h54); send_uart(8'h01); send_uart(8'h2C);
    send_uart(8'h1B); send_uart(8'h43); send_uart(8'h00); send_uart(8'h05);
    send_uart(8'h1B); send_uart(8'h44);
    wait_cyc(3);
    vectors++;
    if ({timebase, charging} !== {16'd300, 16'd5}) begin
      miscompares++; $display("FAIL cfg_before_reset: tb=%0d ch=%0d want 300/5", timebase, charging);
    end
    bus.serial_busy = 1'b1;
    send_lc(8'hA2);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.serial_rd, bus.serial_wr, bus.ledcomm_rd, bus.ledcomm_wr, cfg_strobe} !== 5'd0) begin
      miscompares++; $display("FAIL async_rst_strobes: srd=%b swr=%b lrd=%b lwr=%b cfg=%b want all 0",
        bus.serial_rd, bus.serial_wr, bus.ledcomm_rd, bus.ledcomm_wr, cfg_strobe);
    end
    vectors++;
    if ({timebase, charging} !== {16'd600, 16'd12}) begin
      miscompares++; $display("FAIL async_rst_cfg: tb=%0d ch=%0d want 600/12", timebase, charging);
    end
    vectors++;
    if ({darkness, drop_count} !== 9'd0) begin
      miscompares++; $display("FAIL async_rst_dark: dark=%b drop=%0d want 0/0", darkness, drop_count);
    end
    wait_cyc(2);
    reset = 1'b0;
    bus.serial_busy = 1'b0;
    clr_mon();
    wait_cyc(15);
    vectors++;
    if (sw_q.size() !== 0) begin miscompares++; $display("FAIL rst_rx_discard: got %0d writes want 0", sw_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_forward();
    test_link_down_cmd();
    test_escape();
    test_back_to_back();
    test_link_loss();
    test_uart_egress_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
